mips_multi_cycle_cpu: RTL



---
 rtl/mips_multi_cycle_cpu.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core: FSM-sequenced datapath sharing one ALU and one
// unified instruction/data memory port with a req/ready handshake.
module mips_multi_cycle_cpu #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned MEM_ADDR_W = 32,
  parameter int unsigned TIMEOUT    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic [31:0]           pc,
  output logic                  retire,
  output logic                  halted,
  output logic                  bus_error
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, a_q, b_q, alu_out_q, mdr_q;
  logic [31:0] rf_q [32];
  logic        retire_q, retire_d;
  logic        halted_q, bus_err_q;
  logic [31:0] tmo_cnt_q;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] signimm;
  logic [31:0] rf_rs, rf_rt;

  logic        req_c, we_c;
  logic [31:0] addr_c, addr_full;
  logic        ir_we, pc_we, ab_we, alu_we, mdr_we, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] alu_a, alu_b, alu_y;
  alu_op_t     alu_op, rtype_op;
  logic        rtype_ok;
  logic        mem_wait, tmo_hit;

  assign opcode  = ir_q[31:26];
  assign rs      = ir_q[25:21];
  assign rt      = ir_q[20:16];
  assign rd      = ir_q[15:11];
  assign funct   = ir_q[5:0];
  assign signimm = {{16{ir_q[15]}}, ir_q[15:0]};

  assign rf_rs = (rs == 5'd0) ? '0 : rf_q[rs];
  assign rf_rt = (rt == 5'd0) ? '0 : rf_q[rt];

  always_comb begin
    rtype_ok = 1'b1;
    rtype_op = ALU_ADD;
    case (funct)
      6'h20:   rtype_op = ALU_ADD;
      6'h22:   rtype_op = ALU_SUB;
      6'h24:   rtype_op = ALU_AND;
      6'h25:   rtype_op = ALU_OR;
      6'h2A:   rtype_op = ALU_SLT;
      default: rtype_ok = 1'b0;
    endcase
  end

  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_ADD: alu_y = alu_a + alu_b;
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SLT: alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
      default: alu_y = '0;
    endcase
  end

  // Timeout only counts stalls of an access the FSM is actually making.
  assign mem_wait = req_c && !mem_ready;
  assign tmo_hit  = (TIMEOUT != 0) && mem_wait && (tmo_cnt_q == 32'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_c    = 1'b0;
    we_c     = 1'b0;
    addr_c   = pc_q;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    ab_we    = 1'b0;
    alu_we   = 1'b0;
    mdr_we   = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = alu_out_q;
    retire_d = 1'b0;
    alu_a    = pc_q;
    alu_b    = 32'd4;
    alu_op   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          pc_d    = alu_y;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ab_we  = 1'b1;
        alu_we = 1'b1;
        alu_b  = {signimm[29:0], 2'b00};
        case (opcode)
          OP_RTYPE:     state_d = rtype_ok ? S_EXEC : S_HALT;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        alu_a   = a_q;
        alu_b   = signimm;
        alu_we  = 1'b1;
        state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        req_c  = 1'b1;
        addr_c = alu_out_q;
        if (mem_ready) begin
          mdr_we  = 1'b1;
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_wdata = mdr_q;
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        req_c  = 1'b1;
        we_c   = 1'b1;
        addr_c = alu_out_q;
        if (mem_ready) begin
          retire_d = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_a   = a_q;
        alu_b   = b_q;
        alu_op  = rtype_op;
        alu_we  = 1'b1;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDIEX: begin
        alu_a   = a_q;
        alu_b   = signimm;
        alu_we  = 1'b1;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        rf_we    = 1'b1;
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        // Equality test reuses the ALU subtractor; target was formed in DECODE.
        alu_a    = a_q;
        alu_b    = b_q;
        alu_op   = ALU_SUB;
        pc_we    = (alu_y == 32'd0);
        pc_d     = alu_out_q;
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pc_we    = 1'b1;
        pc_d     = {pc_q[31:28], ir_q[25:0], 2'b00};
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
    if (tmo_hit) begin
      state_d = S_HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      retire_q  <= 1'b0;
      halted_q  <= 1'b0;
      bus_err_q <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      retire_q <= retire_d;
      halted_q <= (state_d == S_HALT);
      if (ir_we)  ir_q      <= mem_rdata;
      if (pc_we)  pc_q      <= pc_d;
      if (alu_we) alu_out_q <= alu_y;
      if (mdr_we) mdr_q     <= mem_rdata;
      if (ab_we) begin
        a_q <= rf_rs;
        b_q <= rf_rt;
      end
      if (tmo_hit) begin
        bus_err_q <= 1'b1;
        tmo_cnt_q <= '0;
      end else if (mem_wait && (TIMEOUT != 0)) begin
        tmo_cnt_q <= tmo_cnt_q + 32'd1;
      end else begin
        tmo_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign addr_full = {addr_c[31:2], 2'b00};
  assign mem_req   = req_c && !reset;
  assign mem_we    = we_c && !reset;
  assign mem_addr  = addr_full[MEM_ADDR_W-1:0];
  assign mem_wdata = b_q;
  assign pc        = pc_q;
  assign retire    = retire_q;
  assign halted    = halted_q;
  assign bus_error = bus_err_q;

endmodule
